gprs_wb_arbiter: RTL and testbench
==================================

Name: gprs_wb_arbiter

Overview:
- Scheduler for the single GPR write port; arbitrates register writeback between three producers.
- Producers: in-order ALU writeback from the WB stage, LSU load return, and the multi-cycle MDU (mul/div).
- Keeps a pending-destination scoreboard so decode stalls on RAW against outstanding LSU/MDU results.
- Sits between the WB stage, LSU and MDU on one side, and the gprs write port (wr_valid/rd_wb/wr_data) plus decode stall logic on the other.

Parameters:
- STARVE_LIMIT, 4: cycles a waiting LSU/MDU request may lose before the ALU path is stalled.
- CNT_WIDTH, 3: width of each starvation counter; must hold STARVE_LIMIT.

Ports:
- cpu_clk  in  1  cpu clock
- cpu_rstn  in  1  synchronous reset, active low
- alu_wb_valid  in  1  ALU result valid in WB
- alu_wb_rd  in  `RD_WIDTH  ALU destination
- alu_wb_data  in  `DATA_WIDTH  ALU result
- lsu_wb_valid  in  1  load data valid; held until lsu_wb_ready
- lsu_wb_ready  out  1  load data accepted this cycle
- lsu_wb_rd  in  `RD_WIDTH  load destination
- lsu_wb_data  in  `DATA_WIDTH  load data
- mdu_wb_valid  in  1  MDU result valid; held until mdu_wb_ready
- mdu_wb_ready  out  1  MDU result accepted this cycle
- mdu_wb_rd  in  `RD_WIDTH  MDU destination
- mdu_wb_data  in  `DATA_WIDTH  MDU result
- lsu_issue  in  1  load issued from EX
- lsu_issue_rd  in  `RD_WIDTH  issued load destination
- mdu_issue  in  1  MDU op issued from EX
- mdu_issue_rd  in  `RD_WIDTH  issued MDU destination
- rs1_dec  in  `RS1_WIDTH  decode source 1
- rs2_dec  in  `RS2_WIDTH  decode source 2
- wr_valid  out  1  gprs write enable
- rd_wb  out  `RD_WIDTH  gprs write index
- wr_data  out  `DATA_WIDTH  gprs write data
- wb_stall  out  1  freeze WB stage; ALU request not consumed
- dec_raw_stall  out  1  decode source matches a pending destination

Behaviour:
- All state updates on posedge cpu_clk.
- cpu_rstn low at the edge clears both counters and the scoreboard.
- During and after reset all ready/stall/wr_valid outputs are 0 until requests arrive.
- Write port outputs are combinational (zero latency); gprs captures them at the same edge.
- Grant priority each cycle:
  1. If lsu_wb_valid and lsu_cnt==STARVE_LIMIT: wb_stall=1, grant LSU.
  2. Else if mdu_wb_valid and mdu_cnt==STARVE_LIMIT: wb_stall=1, grant MDU.
  3. Else if alu_wb_valid: grant ALU.
  4. Else if lsu_wb_valid: grant LSU.
  5. Else if mdu_wb_valid: grant MDU.
- wb_stall=1: pipeline holds alu_wb_* unchanged next cycle; arbiter must not write the ALU value that cycle.
- Ready:
  - lsu_wb_ready / mdu_wb_ready = 1 exactly in the granted cycle; transfer occurs when valid && ready.
  - No ready without valid.
- Port drive:
  - wr_valid=1, rd_wb/wr_data from the grantee.
  - Grant with rd==0: wr_valid=0 (x0 write dropped), ready still asserted.
  - No grant: wr_valid=0, rd_wb=0, wr_data=0.
- Starvation counters (lsu_cnt, mdu_cnt):
  - +1 per cycle valid && !ready, saturating at STARVE_LIMIT.
  - Cleared to 0 on ready or when valid is low.
- Scoreboard: 32-bit pending vector; bit 0 is constant 0.
  - Set pending[lsu_issue_rd] on lsu_issue; set pending[mdu_issue_rd] on mdu_issue.
  - Clear pending[rd] on an LSU/MDU transfer.
  - Set and clear of the same index in one cycle: set wins.
  - ALU writes never touch the scoreboard.
- dec_raw_stall = pending[rs1_dec] || pending[rs2_dec] (registered vector, combinational lookup).

Optional Feature:
- Macro GPRS_WB_BYPASS_EN.
- Defined: a source equal to a nonzero rd being transferred this cycle by LSU/MDU does not cause dec_raw_stall, even though its pending bit is still set. Also adds outputs byp1_hit/byp2_hit (1 bit) and byp_data (`DATA_WIDTH) = transferred data for the decode operand mux.
- Undefined: no bypass ports; dec_raw_stall strictly from the pending vector, one extra stall cycle after each write.

Test Plan:
- ALU rd=5 data=0xA5A5A5A5 alone -> wr_valid=1, rd_wb=5, wr_data=0xA5A5A5A5, wb_stall=0.
- ALU and LSU valid together (STARVE_LIMIT=4) -> ALU granted; after 4 losing cycles, 5th cycle wb_stall=1, lsu_wb_ready=1, ALU data not written; next cycle ALU written; lsu_cnt=0.
- LSU and MDU both starved and valid -> LSU granted first with wb_stall; MDU granted in the next cycle.
- MDU rd=0 data=0xFFFFFFFF -> mdu_wb_ready=1, wr_valid=0.
- mdu_issue rd=7, then rs1_dec=7 -> dec_raw_stall=1 until the MDU rd=7 transfer; cleared the following cycle. With GPRS_WB_BYPASS_EN: stall=0 in the transfer cycle, byp1_hit=1.
- Reset asserted with pending[3]=1 and lsu_cnt=2 -> both cleared after the edge; dec_raw_stall=0 for rs1_dec=3.

Source files
------------

// File: rtl/gprs_wb_arbiter.sv
// gprs_wb_arbiter: schedules the single GPR write port between the in-order
// ALU writeback, LSU load return and MDU (mul/div) result, with starvation
// protection for the LSU/MDU and a pending-destination scoreboard that drives
// the decode RAW stall.
// Optional feature: define GPRS_WB_BYPASS_EN to forward a result being
// transferred this cycle to decode (byp1_hit/byp2_hit/byp_data) and suppress
// the corresponding RAW stall.

`ifndef RD_WIDTH
`define RD_WIDTH 5
`endif
`ifndef RS1_WIDTH
`define RS1_WIDTH 5
`endif
`ifndef RS2_WIDTH
`define RS2_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module gprs_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic                   alu_wb_valid,
    input  logic [`RD_WIDTH-1:0]   alu_wb_rd,
    input  logic [`DATA_WIDTH-1:0] alu_wb_data,
    input  logic                   lsu_wb_valid,
    output logic                   lsu_wb_ready,
    input  logic [`RD_WIDTH-1:0]   lsu_wb_rd,
    input  logic [`DATA_WIDTH-1:0] lsu_wb_data,
    input  logic                   mdu_wb_valid,
    output logic                   mdu_wb_ready,
    input  logic [`RD_WIDTH-1:0]   mdu_wb_rd,
    input  logic [`DATA_WIDTH-1:0] mdu_wb_data,
    input  logic                   lsu_issue,
    input  logic [`RD_WIDTH-1:0]   lsu_issue_rd,
    input  logic                   mdu_issue,
    input  logic [`RD_WIDTH-1:0]   mdu_issue_rd,
    input  logic [`RS1_WIDTH-1:0]  rs1_dec,
    input  logic [`RS2_WIDTH-1:0]  rs2_dec,
    output logic                   wr_valid,
    output logic [`RD_WIDTH-1:0]   rd_wb,
    output logic [`DATA_WIDTH-1:0] wr_data,
    output logic                   wb_stall,
`ifdef GPRS_WB_BYPASS_EN
    output logic                   byp1_hit,
    output logic                   byp2_hit,
    output logic [`DATA_WIDTH-1:0] byp_data,
`endif
    output logic                   dec_raw_stall
);

    localparam int NUM_REGS = 2 ** `RD_WIDTH;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LSU,
        GNT_MDU
    } grant_e;

    logic [CNT_WIDTH-1:0]   r_lsu_cnt;
    logic [CNT_WIDTH-1:0]   r_mdu_cnt;
    logic [NUM_REGS-1:0]    r_pending;
    logic [NUM_REGS-1:0]    w_pending_nxt;
    logic                   w_lsu_starved;
    logic                   w_mdu_starved;
    logic                   w_lsu_xfer;
    logic                   w_mdu_xfer;
    grant_e                 w_grant;
    logic [`RD_WIDTH-1:0]   w_sel_rd;
    logic [`DATA_WIDTH-1:0] w_sel_data;

    assign w_lsu_starved = (r_lsu_cnt == CNT_WIDTH'(STARVE_LIMIT));
    assign w_mdu_starved = (r_mdu_cnt == CNT_WIDTH'(STARVE_LIMIT));

    // Fixed-priority grant: a starved LSU/MDU request pre-empts and freezes the ALU path.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_grant  = GNT_NONE;
        wb_stall = 1'b0;
        if (lsu_wb_valid && w_lsu_starved) begin
            w_grant  = GNT_LSU;
            wb_stall = 1'b1;
        end else if (mdu_wb_valid && w_mdu_starved) begin
            w_grant  = GNT_MDU;
            wb_stall = 1'b1;
        end else if (alu_wb_valid) begin
            w_grant = GNT_ALU;
        end else if (lsu_wb_valid) begin
            w_grant = GNT_LSU;
        end else if (mdu_wb_valid) begin
            w_grant = GNT_MDU;
        end
    end

    // Steer the grantee onto the write port; idle port drives zeros.
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        case (w_grant)
            GNT_ALU: begin
                w_sel_rd   = alu_wb_rd;
                w_sel_data = alu_wb_data;
            end
            GNT_LSU: begin
                w_sel_rd   = lsu_wb_rd;
                w_sel_data = lsu_wb_data;
            end
            GNT_MDU: begin
                w_sel_rd   = mdu_wb_rd;
                w_sel_data = mdu_wb_data;
            end
            default: begin
                w_sel_rd   = '0;
                w_sel_data = '0;
            end
        endcase
    end

    // Writes to x0 are dropped, but the producer is still released.
    assign wr_valid     = (w_grant != GNT_NONE) && (w_sel_rd != '0);
    assign rd_wb        = w_sel_rd;
    assign wr_data      = w_sel_data;
    assign lsu_wb_ready = (w_grant == GNT_LSU);
    assign mdu_wb_ready = (w_grant == GNT_MDU);
    assign w_lsu_xfer   = lsu_wb_valid && lsu_wb_ready;
    assign w_mdu_xfer   = mdu_wb_valid && mdu_wb_ready;

    // Next scoreboard: clear the transferred destination, then apply new issues.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_lsu_xfer || w_mdu_xfer) begin
            w_pending_nxt[w_sel_rd] = 1'b0;
        end
        // NOTE: sets are applied after the clear so an issue to the same index wins.
        if (lsu_issue) begin
            w_pending_nxt[lsu_issue_rd] = 1'b1;
        end
        if (mdu_issue) begin
            w_pending_nxt[mdu_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Starvation counters and scoreboard state, synchronous active-low reset.
    always_ff @(posedge cpu_clk) begin
        // NOTE: reset is sampled on the clock edge only; state uses non-blocking assignments.
        if (!cpu_rstn) begin
            r_lsu_cnt <= '0;
            r_mdu_cnt <= '0;
            r_pending <= '0;
        end else begin
            if (lsu_wb_valid && !lsu_wb_ready) begin
                if (!w_lsu_starved) begin
                    r_lsu_cnt <= r_lsu_cnt + CNT_WIDTH'(1);
                end
            end else begin
                r_lsu_cnt <= '0;
            end
            if (mdu_wb_valid && !mdu_wb_ready) begin
                if (!w_mdu_starved) begin
                    r_mdu_cnt <= r_mdu_cnt + CNT_WIDTH'(1);
                end
            end else begin
                r_mdu_cnt <= '0;
            end
            r_pending <= w_pending_nxt;
        end
    end

`ifdef GPRS_WB_BYPASS_EN
    logic w_xfer;

    // A source matching a nonzero destination transferred this cycle is forwarded, not stalled.
    assign w_xfer        = w_lsu_xfer || w_mdu_xfer;
    assign byp1_hit      = w_xfer && (w_sel_rd != '0) && (rs1_dec == w_sel_rd);
    assign byp2_hit      = w_xfer && (w_sel_rd != '0) && (rs2_dec == w_sel_rd);
    assign byp_data      = w_xfer ? w_sel_data : '0;
    assign dec_raw_stall = (r_pending[rs1_dec] && !byp1_hit) ||
                           (r_pending[rs2_dec] && !byp2_hit);
`else
    assign dec_raw_stall = r_pending[rs1_dec] || r_pending[rs2_dec];
`endif

endmodule

// File: tb/tb_gprs_wb_arbiter.sv
// Self-checking bench for gprs_wb_arbiter: table vectors, hand-written
// starvation/scoreboard/reset sequences and a randomized run against a
// rule-level reference model.
`timescale 1ns/1ps

module tb_gprs_wb_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_WIDTH    = 3;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        alu_wb_valid, lsu_wb_valid, mdu_wb_valid;
    logic [4:0]  alu_wb_rd, lsu_wb_rd, mdu_wb_rd;
    logic [31:0] alu_wb_data, lsu_wb_data, mdu_wb_data;
    logic        lsu_wb_ready, mdu_wb_ready;
    logic        lsu_issue, mdu_issue;
    logic [4:0]  lsu_issue_rd, mdu_issue_rd, rs1_dec, rs2_dec;
    logic        wr_valid, wb_stall, dec_raw_stall;
    logic [4:0]  rd_wb;
    logic [31:0] wr_data;
`ifdef GPRS_WB_BYPASS_EN
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp_data;
`endif

    gprs_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
        .mdu_wb_valid(mdu_wb_valid), .mdu_wb_ready(mdu_wb_ready),
        .mdu_wb_rd(mdu_wb_rd), .mdu_wb_data(mdu_wb_data),
        .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
        .wr_valid(wr_valid), .rd_wb(rd_wb), .wr_data(wr_data),
        .wb_stall(wb_stall),
`ifdef GPRS_WB_BYPASS_EN
        .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data),
`endif
        .dec_raw_stall(dec_raw_stall)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Producer ids: 0 none, 1 ALU, 2 LSU, 3 MDU.
    typedef struct {
        int          g;
        bit          wr_valid;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          lsu_rdy, mdu_rdy, stall, raw, byp1, byp2;
        logic [31:0] bdata;
    } exp_t;

    int   m_lsu_lost, m_mdu_lost;   // consecutive cycles each request has lost
    bit   m_pending [32];
    exp_t last_e;

    function automatic exp_t predict();
        exp_t e;
        bit   xfer;
        e = '{g: 0, wr_valid: 0, rd: 0, data: 0, lsu_rdy: 0, mdu_rdy: 0,
              stall: 0, raw: 0, byp1: 0, byp2: 0, bdata: 0};
        if (lsu_wb_valid && m_lsu_lost == STARVE_LIMIT) begin
            e.g = 2; e.stall = 1;
        end else if (mdu_wb_valid && m_mdu_lost == STARVE_LIMIT) begin
            e.g = 3; e.stall = 1;
        end else if (alu_wb_valid) e.g = 1;
        else if (lsu_wb_valid)     e.g = 2;
        else if (mdu_wb_valid)     e.g = 3;
        if (e.g == 1) begin e.rd = alu_wb_rd; e.data = alu_wb_data; end
        if (e.g == 2) begin e.rd = lsu_wb_rd; e.data = lsu_wb_data; end
        if (e.g == 3) begin e.rd = mdu_wb_rd; e.data = mdu_wb_data; end
        e.lsu_rdy  = (e.g == 2);
        e.mdu_rdy  = (e.g == 3);
        e.wr_valid = (e.g != 0) && (e.rd != 0);
        xfer       = (e.g >= 2);
        e.byp1     = xfer && e.rd != 0 && rs1_dec == e.rd;
        e.byp2     = xfer && e.rd != 0 && rs2_dec == e.rd;
        e.bdata    = xfer ? e.data : 32'h0;
`ifdef GPRS_WB_BYPASS_EN
        e.raw = (m_pending[rs1_dec] && !e.byp1) || (m_pending[rs2_dec] && !e.byp2);
`else
        e.raw = m_pending[rs1_dec] || m_pending[rs2_dec];
`endif
        return e;
    endfunction

    // Wait for the active edge, fold this cycle's inputs into the model, then leave the edge.
    task automatic advance();
        exp_t e;
        @(posedge cpu_clk);
        e = predict();
        if (!cpu_rstn) begin
            m_lsu_lost = 0;
            m_mdu_lost = 0;
            foreach (m_pending[i]) m_pending[i] = 0;
        end else begin
            m_lsu_lost = (lsu_wb_valid && !e.lsu_rdy) ?
                         ((m_lsu_lost < STARVE_LIMIT) ? m_lsu_lost + 1 : STARVE_LIMIT) : 0;
            m_mdu_lost = (mdu_wb_valid && !e.mdu_rdy) ?
                         ((m_mdu_lost < STARVE_LIMIT) ? m_mdu_lost + 1 : STARVE_LIMIT) : 0;
            if (e.g >= 2) m_pending[e.rd] = 0;
            if (lsu_issue) m_pending[lsu_issue_rd] = 1;
            if (mdu_issue) m_pending[mdu_issue_rd] = 1;
            m_pending[0] = 0;
        end
        last_e = e;
        #1;
    endtask

    task automatic settle();
        @(negedge cpu_clk);
    endtask

    task automatic idle_inputs();
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
        mdu_wb_valid = 0; mdu_wb_rd = 0; mdu_wb_data = 0;
        lsu_issue = 0; lsu_issue_rd = 0; mdu_issue = 0; mdu_issue_rd = 0;
        rs1_dec = 0; rs2_dec = 0;
    endtask

    task automatic do_reset();
        cpu_rstn = 0;
        advance();
        cpu_rstn = 1;
    endtask

    // ---------------- table vectors (fresh state each) ----------------
    typedef struct {
        string       name;
        logic        alu_v; logic [4:0] alu_rd; logic [31:0] alu_d;
        logic        lsu_v; logic [4:0] lsu_rd; logic [31:0] lsu_d;
        logic        mdu_v; logic [4:0] mdu_rd; logic [31:0] mdu_d;
        logic        e_wv;  logic [4:0] e_rd;   logic [31:0] e_d;
        logic        e_lr, e_mr, e_st, chk_d;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"alu_alone",     1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0,
                    1, 5, 32'hA5A5A5A5, 0, 0, 0, 1};
        vecs[1] = '{"idle",          0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 1};
        vecs[2] = '{"alu_over_lsu",  1, 2, 32'h11111111, 1, 4, 32'h22222222, 0, 0, 0,
                    1, 2, 32'h11111111, 0, 0, 0, 1};
        vecs[3] = '{"alu_over_mdu",  1, 3, 32'h33333333, 0, 0, 0, 1, 6, 32'h66666666,
                    1, 3, 32'h33333333, 0, 0, 0, 1};
        vecs[4] = '{"lsu_over_mdu",  0, 0, 0, 1, 8, 32'h88888888, 1, 9, 32'h99999999,
                    1, 8, 32'h88888888, 1, 0, 0, 1};
        vecs[5] = '{"mdu_alone",     0, 0, 0, 0, 0, 0, 1, 31, 32'hCAFEF00D,
                    1, 31, 32'hCAFEF00D, 0, 1, 0, 1};
        vecs[6] = '{"mdu_x0",        0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF,
                    0, 0, 0, 0, 1, 0, 0};
        vecs[7] = '{"alu_x0",        1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{"alu_over_both", 1, 1, 32'h0000_0001, 1, 2, 32'h2, 1, 3, 32'h3,
                    1, 1, 32'h0000_0001, 0, 0, 0, 1};
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t v;
        idle_inputs();
        m_lsu_lost = 0; m_mdu_lost = 0;
        foreach (m_pending[i]) m_pending[i] = 0;

        // Outputs quiet during reset with no requests.
        cpu_rstn = 0;
        settle();
        check("rst.wr_valid", 32'(wr_valid), 0);
        check("rst.lsu_ready", 32'(lsu_wb_ready), 0);
        check("rst.mdu_ready", 32'(mdu_wb_ready), 0);
        check("rst.wb_stall", 32'(wb_stall), 0);
        advance();
        advance();
        cpu_rstn = 1;
        settle();
        check("rst.raw_stall", 32'(dec_raw_stall), 0);
        check("rst.wr_valid_after", 32'(wr_valid), 0);
        advance();

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            do_reset();
            alu_wb_valid = v.alu_v; alu_wb_rd = v.alu_rd; alu_wb_data = v.alu_d;
            lsu_wb_valid = v.lsu_v; lsu_wb_rd = v.lsu_rd; lsu_wb_data = v.lsu_d;
            mdu_wb_valid = v.mdu_v; mdu_wb_rd = v.mdu_rd; mdu_wb_data = v.mdu_d;
            settle();
            check($sformatf("%s.wr_valid", v.name), 32'(wr_valid), 32'(v.e_wv));
            check($sformatf("%s.lsu_ready", v.name), 32'(lsu_wb_ready), 32'(v.e_lr));
            check($sformatf("%s.mdu_ready", v.name), 32'(mdu_wb_ready), 32'(v.e_mr));
            check($sformatf("%s.wb_stall", v.name), 32'(wb_stall), 32'(v.e_st));
            if (v.chk_d) begin
                check($sformatf("%s.rd_wb", v.name), 32'(rd_wb), 32'(v.e_rd));
                check($sformatf("%s.wr_data", v.name), wr_data, v.e_d);
            end
            advance();
            idle_inputs();
        end

        // LSU starvation against a continuous ALU stream.
        do_reset();
        lsu_wb_valid = 1; lsu_wb_rd = 4; lsu_wb_data = 32'hDEAD0004;
        alu_wb_valid = 1; alu_wb_rd = 3;
        for (int k = 1; k <= 4; k++) begin
            alu_wb_data = 32'h100 + k;
            settle();
            check($sformatf("starve.c%0d.rd_wb", k), 32'(rd_wb), 3);
            check($sformatf("starve.c%0d.wr_data", k), wr_data, 32'h100 + k);
            check($sformatf("starve.c%0d.lsu_ready", k), 32'(lsu_wb_ready), 0);
            check($sformatf("starve.c%0d.wb_stall", k), 32'(wb_stall), 0);
            advance();
        end
        alu_wb_data = 32'h200;
        settle();
        check("starve.c5.wb_stall", 32'(wb_stall), 1);
        check("starve.c5.lsu_ready", 32'(lsu_wb_ready), 1);
        check("starve.c5.wr_valid", 32'(wr_valid), 1);
        check("starve.c5.rd_wb", 32'(rd_wb), 4);
        check("starve.c5.wr_data", wr_data, 32'hDEAD0004);
        advance();
        lsu_wb_valid = 0;
        settle();
        check("starve.c6.wr_data", wr_data, 32'h200);
        check("starve.c6.rd_wb", 32'(rd_wb), 3);
        check("starve.c6.wb_stall", 32'(wb_stall), 0);
        advance();
        lsu_wb_valid = 1; lsu_wb_rd = 5; lsu_wb_data = 32'h5;
        settle();
        check("starve.cnt_cleared.wb_stall", 32'(wb_stall), 0);
        check("starve.cnt_cleared.lsu_ready", 32'(lsu_wb_ready), 0);
        advance();
        idle_inputs();

        // LSU and MDU both starved: LSU first, MDU next, then ALU resumes.
        do_reset();
        alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 32'hA1;
        lsu_wb_valid = 1; lsu_wb_rd = 2; lsu_wb_data = 32'hB2;
        mdu_wb_valid = 1; mdu_wb_rd = 3; mdu_wb_data = 32'hC3;
        for (int k = 1; k <= 4; k++) begin
            settle();
            check($sformatf("both.c%0d.rd_wb", k), 32'(rd_wb), 1);
            advance();
        end
        settle();
        check("both.lsu.wb_stall", 32'(wb_stall), 1);
        check("both.lsu.lsu_ready", 32'(lsu_wb_ready), 1);
        check("both.lsu.mdu_ready", 32'(mdu_wb_ready), 0);
        check("both.lsu.rd_wb", 32'(rd_wb), 2);
        advance();
        lsu_wb_valid = 0;
        settle();
        check("both.mdu.wb_stall", 32'(wb_stall), 1);
        check("both.mdu.mdu_ready", 32'(mdu_wb_ready), 1);
        check("both.mdu.wr_data", wr_data, 32'hC3);
        advance();
        mdu_wb_valid = 0;
        settle();
        check("both.alu.rd_wb", 32'(rd_wb), 1);
        check("both.alu.wb_stall", 32'(wb_stall), 0);
        advance();
        idle_inputs();

        // Scoreboard: MDU rd=7 pending until its transfer.
        do_reset();
        mdu_issue = 1; mdu_issue_rd = 7;
        advance();
        mdu_issue = 0; rs1_dec = 7;
        settle();
        check("sb.pending.c1", 32'(dec_raw_stall), 1);
        advance();
        settle();
        check("sb.pending.c2", 32'(dec_raw_stall), 1);
        advance();
        mdu_wb_valid = 1; mdu_wb_rd = 7; mdu_wb_data = 32'h7777_0007;
        settle();
        check("sb.xfer.mdu_ready", 32'(mdu_wb_ready), 1);
`ifdef GPRS_WB_BYPASS_EN
        check("sb.xfer.raw_stall", 32'(dec_raw_stall), 0);
        check("sb.xfer.byp1_hit", 32'(byp1_hit), 1);
        check("sb.xfer.byp2_hit", 32'(byp2_hit), 0);
        check("sb.xfer.byp_data", byp_data, 32'h7777_0007);
`else
        check("sb.xfer.raw_stall", 32'(dec_raw_stall), 1);
`endif
        advance();
        mdu_wb_valid = 0;
        settle();
        check("sb.after.raw_stall", 32'(dec_raw_stall), 0);
        advance();

        // Set and clear of the same index in one cycle: set wins.
        lsu_issue = 1; lsu_issue_rd = 6;
        advance();
        lsu_wb_valid = 1; lsu_wb_rd = 6; lsu_wb_data = 32'h66;
        settle();
        check("setwins.xfer.lsu_ready", 32'(lsu_wb_ready), 1);
        advance();
        lsu_issue = 0; lsu_wb_valid = 0; rs2_dec = 6; rs1_dec = 0;
        settle();
        check("setwins.raw_stall", 32'(dec_raw_stall), 1);
        advance();
        idle_inputs();

        // Reset clears a set pending bit and a partial starvation count.
        do_reset();
        lsu_issue = 1; lsu_issue_rd = 3;
        advance();
        lsu_issue = 0;
        alu_wb_valid = 1; alu_wb_rd = 1; alu_wb_data = 32'h1;
        lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 32'h9;
        advance();
        advance();
        rs1_dec = 3;
        settle();
        check("rstclr.before.raw_stall", 32'(dec_raw_stall), 1);
        cpu_rstn = 0;
        advance();
        cpu_rstn = 1;
        for (int k = 1; k <= 4; k++) begin
            settle();
            if (k == 1) check("rstclr.raw_stall", 32'(dec_raw_stall), 0);
            check($sformatf("rstclr.c%0d.wb_stall", k), 32'(wb_stall), 0);
            advance();
        end
        settle();
        check("rstclr.c5.wb_stall", 32'(wb_stall), 1);
        check("rstclr.c5.lsu_ready", 32'(lsu_wb_ready), 1);
        advance();
        idle_inputs();

        // Randomized traffic against the model; producers honour hold-until-ready.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            exp_t e;
            if (!(alu_wb_valid && last_e.stall)) begin
                alu_wb_valid = ($urandom_range(0, 2) != 0);
                alu_wb_rd    = 5'($urandom_range(0, 7));
                alu_wb_data  = $urandom;
            end
            if (!(lsu_wb_valid && !last_e.lsu_rdy)) begin
                lsu_wb_valid = ($urandom_range(0, 2) != 0);
                lsu_wb_rd    = 5'($urandom_range(0, 7));
                lsu_wb_data  = $urandom;
            end
            if (!(mdu_wb_valid && !last_e.mdu_rdy)) begin
                mdu_wb_valid = ($urandom_range(0, 1) != 0);
                mdu_wb_rd    = 5'($urandom_range(0, 7));
                mdu_wb_data  = $urandom;
            end
            lsu_issue    = ($urandom_range(0, 3) == 0);
            lsu_issue_rd = 5'($urandom_range(0, 7));
            mdu_issue    = ($urandom_range(0, 3) == 0);
            mdu_issue_rd = 5'($urandom_range(0, 7));
            rs1_dec      = 5'($urandom_range(0, 7));
            rs2_dec      = 5'($urandom_range(0, 7));
            settle();
            e = predict();
            check("rand.wr_valid", 32'(wr_valid), 32'(e.wr_valid));
            check("rand.lsu_ready", 32'(lsu_wb_ready), 32'(e.lsu_rdy));
            check("rand.mdu_ready", 32'(mdu_wb_ready), 32'(e.mdu_rdy));
            check("rand.wb_stall", 32'(wb_stall), 32'(e.stall));
            check("rand.raw_stall", 32'(dec_raw_stall), 32'(e.raw));
            if (e.wr_valid || e.g == 0) begin
                check("rand.rd_wb", 32'(rd_wb), 32'(e.rd));
                check("rand.wr_data", wr_data, e.data);
            end
`ifdef GPRS_WB_BYPASS_EN
            check("rand.byp1_hit", 32'(byp1_hit), 32'(e.byp1));
            check("rand.byp2_hit", 32'(byp2_hit), 32'(e.byp2));
            check("rand.byp_data", byp_data, e.bdata);
`endif
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
